// File: rtl/vgachargen_pkg.sv
// vgachargen_pkg: shared map geometry, region/state encodings and APB address decode.
package vgachargen_pkg;
    localparam int MAP_COLS = 80;
    localparam int MAP_ROWS = 30;
    localparam int MAP_DEPTH = MAP_COLS * MAP_ROWS;
    localparam int MAP_ADDR_W = $clog2(MAP_DEPTH);
    localparam logic [31:0] ID_VALUE = 32'h5647_4331;

    typedef enum logic [1:0] {CH_MAP, COL_MAP, ID_REG, ILLEGAL} region_e;
    typedef enum logic [1:0] {IDLE, ACCESS, RD_DATA} state_e;

    typedef struct packed {
        region_e region;
        logic    err;
    } dec_t;

    // Index is the word offset within the 16 KiB region selected by a[15:14].
    function automatic dec_t decode(input logic [15:0] a, input logic wr, input int unsigned depth);
        dec_t d;
        logic [11:0] idx;
        idx = a[13:2];
        d.region = region_e'(a[15:14]);
        d.err = (a[1:0] != 2'b00) || (d.region == ILLEGAL) ||
                (d.region == ID_REG && (idx != 12'd0 || wr)) ||
                ((d.region == CH_MAP || d.region == COL_MAP) && 32'(idx) >= depth);
        return d;
    endfunction
endpackage

// File: rtl/apb_vgachargen_regif.sv
// apb_vgachargen_regif: APB3 slave giving CPU access to the text-mode character and colour maps.
module apb_vgachargen_regif #(
    parameter int          APB_ADDR_W = 32,
    parameter int          MAP_DEPTH  = vgachargen_pkg::MAP_DEPTH,
    parameter logic [31:0] ID_VALUE   = vgachargen_pkg::ID_VALUE
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         psel_i,
    input  logic                         penable_i,
    input  logic                         pwrite_i,
    input  logic [APB_ADDR_W-1:0]        paddr_i,
    input  logic [31:0]                  pwdata_i,
    output logic [31:0]                  prdata_o,
    output logic                         pready_o,
    output logic                         pslverr_o,
    output logic [$clog2(MAP_DEPTH)-1:0] ch_map_addr_o,
    output logic [7:0]                   ch_map_data_o,
    output logic                         ch_map_wen_o,
    input  logic [7:0]                   ch_map_data_i,
    output logic [$clog2(MAP_DEPTH)-1:0] col_map_addr_o,
    output logic [7:0]                   col_map_data_o,
    output logic                         col_map_wen_o,
    input  logic [7:0]                   col_map_data_i
);
    import vgachargen_pkg::*;

    localparam int AW = $clog2(MAP_DEPTH);

    state_e      state_q, state_d;
    logic        pready_q, pready_d, pslverr_q, pslverr_d;
    logic        rd_q, rd_d, col_q, col_d;
    logic [31:0] prdata_q, prdata_d;
    logic [AW-1:0] ch_addr_q, ch_addr_d, col_addr_q, col_addr_d;
    logic [7:0]  ch_data_q, ch_data_d, col_data_q, col_data_d;
    logic        ch_wen_q, ch_wen_d, col_wen_q, col_wen_d;
    dec_t        dec;
    logic [11:0] idx;
    logic        setup, map_ok;
    logic        unused_bits;

    assign unused_bits = ^{paddr_i[APB_ADDR_W-1:16], pwdata_i[31:8]};

    always_comb begin
        dec        = decode(paddr_i[15:0], pwrite_i, MAP_DEPTH);
        idx        = paddr_i[13:2];
        setup      = psel_i && !penable_i;
        map_ok     = !dec.err && (dec.region == CH_MAP || dec.region == COL_MAP);
        state_d    = state_q;
        pready_d   = 1'b0;
        pslverr_d  = 1'b0;
        prdata_d   = 32'd0;
        rd_d       = rd_q;
        col_d      = col_q;
        ch_addr_d  = ch_addr_q;
        ch_data_d  = ch_data_q;
        col_addr_d = col_addr_q;
        col_data_d = col_data_q;
        ch_wen_d   = 1'b0;
        col_wen_d  = 1'b0;
        case (state_q)
            IDLE: if (setup) begin
                state_d   = ACCESS;
                pready_d  = dec.err || pwrite_i || dec.region == ID_REG;
                pslverr_d = dec.err;
                prdata_d  = (!dec.err && !pwrite_i && dec.region == ID_REG) ? ID_VALUE : 32'd0;
                rd_d      = map_ok && !pwrite_i;
                col_d     = dec.region == COL_MAP;
                if (map_ok && dec.region == CH_MAP) begin
                    ch_addr_d = idx[AW-1:0];
                    ch_data_d = pwrite_i ? pwdata_i[7:0] : ch_data_q;
                    ch_wen_d  = pwrite_i;
                end
                if (map_ok && dec.region == COL_MAP) begin
                    col_addr_d = idx[AW-1:0];
                    col_data_d = pwrite_i ? pwdata_i[7:0] : col_data_q;
                    col_wen_d  = pwrite_i;
                end
            end
            // Only a still-selected map read waits for the BRAM; everything else is done.
            ACCESS: begin
                state_d  = (psel_i && rd_q) ? RD_DATA : IDLE;
                pready_d = psel_i && rd_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            prdata_q   <= 32'd0;
            rd_q       <= 1'b0;
            col_q      <= 1'b0;
            ch_addr_q  <= '0;
            ch_data_q  <= 8'd0;
            col_addr_q <= '0;
            col_data_q <= 8'd0;
            ch_wen_q   <= 1'b0;
            col_wen_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pready_q   <= pready_d;
            pslverr_q  <= pslverr_d;
            prdata_q   <= prdata_d;
            rd_q       <= rd_d;
            col_q      <= col_d;
            ch_addr_q  <= ch_addr_d;
            ch_data_q  <= ch_data_d;
            col_addr_q <= col_addr_d;
            col_data_q <= col_data_d;
            ch_wen_q   <= ch_wen_d;
            col_wen_q  <= col_wen_d;
        end
    end

    // BRAM output is already registered, so it is muxed straight onto the bus in RD_DATA.
    assign prdata_o       = (state_q == RD_DATA) ? {24'd0, col_q ? col_map_data_i : ch_map_data_i} : prdata_q;
    assign pready_o       = pready_q;
    assign pslverr_o      = pslverr_q;
    assign ch_map_addr_o  = ch_addr_q;
    assign ch_map_data_o  = ch_data_q;
    assign ch_map_wen_o   = ch_wen_q;
    assign col_map_addr_o = col_addr_q;
    assign col_map_data_o = col_data_q;
    assign col_map_wen_o  = col_wen_q;
endmodule

// File: doc/apb_vgachargen_regif.md
# apb_vgachargen_regif

APB3 slave that gives a CPU write and read access to the 80×30 character map and colour map of the text-mode VGA character generator. It sits directly upstream of the text-mode top level. It turns APB transfers into single-cycle write strobes and fixed-latency reads on the two map ports of that stage, adding wait states where the BRAM read latency needs them. It also decodes address errors and provides a read-only ID register.

## Interface
Parameters:
- APB_ADDR_W, 32: PADDR width; only bits [15:0] are decoded.
- MAP_DEPTH, 2400: map entries (80×30); valid index range 0..MAP_DEPTH-1.
- ID_VALUE, 32'h5647_4331: ID register contents.

Ports:
- clk  in  1  single clock, which is also the character-generator pixel clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous, active-high reset.
- psel_i, penable_i, pwrite_i  in  1  APB3 control.
- paddr_i  in  APB_ADDR_W  byte address.
- pwdata_i  in  32  write data; bits [7:0] are used.
- prdata_o  out  32  read data, zero-extended.
- pready_o  out  1  transfer complete.
- pslverr_o  out  1  error response; valid while pready_o=1.
- ch_map_addr_o, col_map_addr_o  out  $clog2(MAP_DEPTH)  map index.
- ch_map_data_o, col_map_data_o  out  8  write data.
- ch_map_wen_o, col_map_wen_o  out  1  one-cycle write strobe.
- ch_map_data_i, col_map_data_i  in  8  map read data, 1-cycle BRAM latency.

## Operation
Address decode, registered at the end of the APB setup phase:
- paddr[15:14]=00: character map.
- paddr[15:14]=01: colour map.
- paddr[15:14]=10 with paddr[13:2]=0: ID register, read-only.
- Index = paddr[13:2].

An access is an error if any of these hold. An error asserts no wen and completes in the first access cycle with pslverr_o=1 and prdata_o=0.
- paddr[1:0]≠0.
- Map index ≥ MAP_DEPTH.
- Region 11.
- Region 10 with a nonzero index.
- A write to the ID register.

FSM states:
- IDLE: entered from reset.
- IDLE→ACCESS on psel_i & !penable_i (setup phase). On that edge, latch region, index, write data, write flag and error flag.
- ACCESS: first access cycle.
  - Valid map write: the matching wen is high for this cycle only, and pready_o=1 → IDLE.
  - Error or ID read: pready_o=1 → IDLE.
  - Valid map read: pready_o=0 → RD_DATA.
- RD_DATA: the BRAM data is valid. prdata_o={24'b0, data_i of the selected map}, pready_o=1 → IDLE.
- Abandoned transfer: if psel_i=0 in ACCESS or RD_DATA, go to IDLE with no further strobe. A write strobe already issued is not retracted.
- Map address and data outputs hold their last value between transfers. wen outputs are high only in ACCESS of a valid write.
- prdata_o and pslverr_o are zero whenever pready_o=0.
- Reset, including mid-transfer: state=IDLE. pready_o, pslverr_o, prdata_o, both wen, both addr and both data outputs = 0.

## Timing
- Cycle 0 is the setup phase.
- Write: wen in cycle 1, with pready_o=1 in the same cycle. The BRAM captures the write at the end of cycle 1. Zero wait states.
- Map read: address presented in cycle 1, pready_o=0. Data and pready_o=1 in cycle 2. One wait state.
- Error or ID read: completes in cycle 1.
- Back-to-back transfers: a new setup phase may follow immediately in the cycle after pready_o=1. The earliest next wen is 2 cycles after the previous one.
- No combinational path from APB inputs to pready_o, prdata_o or pslverr_o; all are registered from the FSM.

## Structure
- Package vgachargen_pkg holds:
  - MAP_COLS=80, MAP_ROWS=30, MAP_DEPTH, MAP_ADDR_W.
  - Region enum: CH_MAP, COL_MAP, ID_REG, ILLEGAL.
  - FSM state enum: IDLE, ACCESS, RD_DATA.
  - ID_VALUE.
  - Decode function returning region and error flag.
- No sub-module. Single module of about 150–200 lines.

## Test plan
- Write 0x41 to 0x0000_0010 → ch_map_wen_o high exactly one cycle (cycle 1), ch_map_addr_o=4, ch_map_data_o=0x41, pready_o=1, pslverr_o=0.
- Read 0x0000_4008 with col_map_data_i=0xF0 in cycle 2 → pready_o low in cycle 1, high in cycle 2, prdata_o=0x0000_00F0.
- Read 0x0000_8000 → prdata_o=0x5647_4331 in cycle 1. Write 0x0000_8000 → pslverr_o=1, no wen.
- Access to 0x0000_2580 (index 2400), 0x0000_0011 (misaligned) and 0x0000_C000 → each gives pslverr_o=1 in cycle 1, both wen low.
- Back-to-back write, read, write to the char map at indices 0, 1 and 2399 → strobes and data are correct, and reading index 2399 returns the written value.
- rst asserted in RD_DATA → next cycle all outputs 0. A following read completes normally.
